// File: rtl/data_io_host.sv
// Host-side driver for the 23-bit command bus / 6-bit response bus of the
// accelerator I/O front end: one command per handshake, fixed settle time,
// then the sampled response is returned on a valid/ready handshake.
module data_io_host #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_opcode,
  input  logic        req_write,
  input  logic [18:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_status,
  output logic [3:0]  rsp_result,
  output logic [22:0] bus_out,
  input  logic [5:0]  bus_in,
  output logic        busy,
  output logic [15:0] wr_count
);

  localparam int unsigned BUS_W = 23;
  localparam int unsigned LOW_W = 21;
  localparam int unsigned WC_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [BUS_W-1:0]  bus_n;
  logic              tog, tog_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              rsp_valid_n;
  logic [1:0]        rsp_status_n;
  logic [3:0]        rsp_result_n;
  logic [WC_W-1:0]   wr_count_n;

  // Ready is forced low while reset is held so nothing is accepted during reset.
  assign req_ready = rstn && (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      bus_out    <= '0;
      tog        <= 1'b0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_status <= '0;
      rsp_result <= '0;
      wr_count   <= '0;
    end else begin
      state      <= state_n;
      bus_out    <= bus_n;
      tog        <= tog_n;
      cnt        <= cnt_n;
      rsp_valid  <= rsp_valid_n;
      rsp_status <= rsp_status_n;
      rsp_result <= rsp_result_n;
      wr_count   <= wr_count_n;
    end
  end

  // Next-state and next-datapath logic; everything holds unless a state acts.
  always_comb begin
    state_n      = state;
    bus_n        = bus_out;
    tog_n        = tog;
    cnt_n        = cnt;
    rsp_valid_n  = rsp_valid;
    rsp_status_n = rsp_status;
    rsp_result_n = rsp_result;
    wr_count_n   = wr_count;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_write) begin
            // Parity field {we, tog} always changes, so the receiver sees a strobe.
            tog_n      = ~tog;
            bus_n      = {req_opcode, 1'b1, ~tog, req_data};
            wr_count_n = wr_count + WC_W'(1);
          end else begin
            // Opcode-only: low field untouched so no data is latched.
            bus_n = {req_opcode, bus_out[LOW_W-1:0]};
          end
          cnt_n   = CNT_W'(WAIT_CYCLES);
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          rsp_status_n = bus_in[5:4];
          rsp_result_n = bus_in[3:0];
          rsp_valid_n  = 1'b1;
          state_n      = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_io_host.sv
// Self-checking bench for data_io_host: vector table plus response scoreboard.
module tb_data_io_host;

  localparam int unsigned WAIT_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_opcode = '0;
  logic        req_write = 1'b0;
  logic [18:0] req_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_status;
  logic [3:0]  rsp_result;
  logic [22:0] bus_out;
  logic [5:0]  bus_in = '0;
  logic        busy;
  logic [15:0] wr_count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  op;
    logic        wr;
    logic [18:0] data;
    logic [5:0]  bin;
    int          hold;
    logic [22:0] exp_bus;
    logic [15:0] exp_wc;
    logic [1:0]  exp_st;
    logic [3:0]  exp_res;
  } vec_t;

  typedef struct {
    logic [1:0] st;
    logic [3:0] res;
  } rsp_t;

  vec_t vecs[5];
  rsp_t sb[$];

  data_io_host #(.WAIT_CYCLES(WAIT_CYCLES), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_write(req_write), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_result(rsp_result),
    .bus_out(bus_out), .bus_in(bus_in),
    .busy(busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Drive one command, push its expected response, return just after the accept edge.
  task automatic send(input logic [1:0] op, input logic wr, input logic [18:0] d,
                      input logic [5:0] bin, input logic [1:0] est, input logic [3:0] eres);
    int n = 0;
    rsp_t e;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_ready", 32'(req_ready), 32'd1);
    bus_in = bin;
    req_valid = 1'b1; req_opcode = op; req_write = wr; req_data = d;
    e.st = est; e.res = eres;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_opcode = ~op; req_write = ~wr; req_data = 19'($urandom);
  endtask

  // Wait for the response, compare with the scoreboard, apply backpressure, then release.
  task automatic get_rsp(input int hold);
    int n = 0;
    rsp_t e;
    do begin
      @(posedge clk); #1; n++;
    end while (!rsp_valid && n < 40);
    chk("rsp_latency", 32'(n), 32'(WAIT_CYCLES + 1));
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd1);
      e.st = '0; e.res = '0;
    end else begin
      e = sb.pop_front();
    end
    chk("rsp_status", 32'(rsp_status), 32'(e.st));
    chk("rsp_result", 32'(rsp_result), 32'(e.res));
    for (int i = 0; i < hold; i++) begin
      bus_in = 6'($urandom);
      @(posedge clk); #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_status", 32'(rsp_status), 32'(e.st));
      chk("bp_result", 32'(rsp_result), 32'(e.res));
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rel_valid", 32'(rsp_valid), 32'd0);
    chk("rel_busy", 32'(busy), 32'd0);
    chk("rel_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    bit seen;
    vecs[0] = '{2'b01, 1'b1, 19'h12345, 6'b10_1010, 0,  {2'b01, 2'b11, 19'h12345}, 16'd1, 2'b10, 4'hA};
    vecs[1] = '{2'b00, 1'b1, 19'h00001, 6'b01_0101, 0,  {2'b00, 2'b10, 19'h00001}, 16'd2, 2'b01, 4'h5};
    vecs[2] = '{2'b10, 1'b1, 19'h7FFFF, 6'b11_1111, 10, {2'b10, 2'b11, 19'h7FFFF}, 16'd3, 2'b11, 4'hF};
    vecs[3] = '{2'b11, 1'b0, 19'h55555, 6'b00_0000, 0,  {2'b11, 2'b11, 19'h7FFFF}, 16'd3, 2'b00, 4'h0};
    vecs[4] = '{2'b01, 1'b1, 19'h0ABCD, 6'b10_1100, 0,  {2'b01, 2'b10, 19'h0ABCD}, 16'd4, 2'b10, 4'hC};

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_bus", 32'(bus_out), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_wc", 32'(wr_count), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
    end
    rstn = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Table-driven command sequence.
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].op, vecs[i].wr, vecs[i].data, vecs[i].bin, vecs[i].exp_st, vecs[i].exp_res);
      chk($sformatf("v%0d_bus", i), 32'(bus_out), 32'(vecs[i].exp_bus));
      chk($sformatf("v%0d_wc", i), 32'(wr_count), 32'(vecs[i].exp_wc));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'd0);
      get_rsp(vecs[i].hold);
      chk($sformatf("v%0d_bus_hold", i), 32'(bus_out), 32'(vecs[i].exp_bus));
    end

    // Reset in the middle of WAIT: in-flight command dropped.
    send(2'b10, 1'b1, 19'h11111, 6'h3F, 2'b11, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_bus", 32'(bus_out), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_wc", 32'(wr_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    sb.delete();
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < int'(WAIT_CYCLES) + 3; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("mid_no_rsp", 32'(seen), 32'd0);

    // Back-to-back writes after reset: parity restarts at 11.
    send(2'b00, 1'b1, 19'h00001, 6'h21, 2'b10, 4'h1);
    chk("b2b0_bus", 32'(bus_out), 32'({2'b00, 2'b11, 19'h00001}));
    chk("b2b0_wc", 32'(wr_count), 32'd1);
    get_rsp(0);
    send(2'b01, 1'b1, 19'h7FFFF, 6'h17, 2'b01, 4'h7);
    chk("b2b1_bus", 32'(bus_out), 32'({2'b01, 2'b10, 19'h7FFFF}));
    chk("b2b1_wc", 32'(wr_count), 32'd2);
    get_rsp(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
